// File: rtl/grey2rgb_colorize_pkg.sv
// Shared types and constants for the grey-to-RGB colorizer: FSM states, widths
// and the preset channel gains.
package grey2rgb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int PIX_W = 8;
  localparam int RGB_W = 24;
  localparam int ACC_W = 2 * PIX_W;

  localparam logic [ACC_W-1:0] ROUND_BIAS = 16'h0080;

  localparam logic [PIX_W-1:0] LUMA_R  = 8'h4D;
  localparam logic [PIX_W-1:0] LUMA_G  = 8'h97;
  localparam logic [PIX_W-1:0] LUMA_B  = 8'h1D;
  localparam logic [PIX_W-1:0] SEPIA_R = 8'hFF;
  localparam logic [PIX_W-1:0] SEPIA_G = 8'hC0;
  localparam logic [PIX_W-1:0] SEPIA_B = 8'h80;

endpackage

// File: rtl/grey2rgb_colorize_if.sv
// Pixel-in / RGB-out handshake bundle; slave is the colorizer's view,
// master is the driving side.
interface grey2rgb_colorize_if;
  import grey2rgb_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] grey_pixel;
  logic [PIX_W-1:0] coef_r;
  logic [PIX_W-1:0] coef_g;
  logic [PIX_W-1:0] coef_b;
  logic             out_valid;
  logic             out_ready;
  logic [RGB_W-1:0] rgb_pixel;
  logic             busy;

  modport slave (
    input  in_valid, grey_pixel, coef_r, coef_g, coef_b, out_ready,
    output in_ready, out_valid, rgb_pixel, busy
  );

  modport master (
    output in_valid, grey_pixel, coef_r, coef_g, coef_b, out_ready,
    input  in_ready, out_valid, rgb_pixel, busy
  );

endinterface

// File: rtl/grey2rgb_colorize_mac.sv
// shift_add_mac8: serial shift-add multiplier, one multiplier bit per cycle.
// sum is the accumulator value the current step would produce.
module shift_add_mac8 #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      step,
  input  logic                      bit_in,
  input  logic [$clog2(DATA_W)-1:0] k,
  input  logic [COEF_W-1:0]         coef_in,
  output logic [DATA_W+COEF_W-1:0]  sum
);

  localparam int ACC_W = DATA_W + COEF_W;

  logic [ACC_W-1:0]  acc;
  logic [COEF_W-1:0] coef_q;
  logic [ACC_W-1:0]  addend;

  // Gain is captured with the pixel so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (clear) coef_q <= coef_in;
  end

  assign addend = bit_in ? ({{DATA_W{1'b0}}, coef_q} << k) : '0;
  assign sum    = acc + addend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        acc <= '0;
    else if (clear) acc <= '0;
    else if (step)  acc <= sum;
  end

endmodule

// File: rtl/grey2rgb_colorize.sv
// Grey-to-RGB colorizer: scales a grey sample by three Q0.8 gains using
// serial shift-add MACs. Define GREY2RGB_ROUND_EN for round-half-up outputs.
module grey2rgb_colorize
  import grey2rgb_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  grey2rgb_colorize_if.slave   bus
);

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       cnt;
  logic [PIX_W-1:0] grey_q;
  logic             accept;
  logic             step;
  logic             last_bit;
  logic [ACC_W-1:0] sum_r;
  logic [ACC_W-1:0] sum_g;
  logic [ACC_W-1:0] sum_b;
  logic [RGB_W-1:0] rgb_q;
  logic             out_valid_q;

  function automatic logic [PIX_W-1:0] chan_out(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] adj;
`ifdef GREY2RGB_ROUND_EN
    adj = acc + ROUND_BIAS;
`else
    adj = acc;
`endif
    return adj[ACC_W-1:PIX_W];
  endfunction

  assign bus.in_ready  = !rst && ((state == IDLE) || ((state == HOLD) && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign step          = (state == MUL);
  assign last_bit      = step && (cnt == 3'd7);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.rgb_pixel = rgb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MUL;
      MUL:     if (cnt == 3'd7) state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = bus.in_valid ? MUL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= 3'd0;
    else if (accept) cnt <= 3'd0;
    else if (step)   cnt <= cnt + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (accept) grey_q <= bus.grey_pixel;
  end

  // Result registers load from the MAC sums on the k=7 edge itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      if (last_bit) begin
        out_valid_q <= 1'b1;
        rgb_q       <= {chan_out(sum_r), chan_out(sum_g), chan_out(sum_b)};
      end else if ((state == HOLD) && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  shift_add_mac8 #(.DATA_W(PIX_W), .COEF_W(PIX_W)) u_mac_r (
    .clk(clk), .rst(rst), .clear(accept), .step(step), .bit_in(grey_q[cnt]),
    .k(cnt), .coef_in(bus.coef_r), .sum(sum_r)
  );

  shift_add_mac8 #(.DATA_W(PIX_W), .COEF_W(PIX_W)) u_mac_g (
    .clk(clk), .rst(rst), .clear(accept), .step(step), .bit_in(grey_q[cnt]),
    .k(cnt), .coef_in(bus.coef_g), .sum(sum_g)
  );

  shift_add_mac8 #(.DATA_W(PIX_W), .COEF_W(PIX_W)) u_mac_b (
    .clk(clk), .rst(rst), .clear(accept), .step(step), .bit_in(grey_q[cnt]),
    .k(cnt), .coef_in(bus.coef_b), .sum(sum_b)
  );

endmodule

// File: tb/tb_grey2rgb_colorize.sv
// Directed bench for grey2rgb_colorize: reset, latency, boundaries,
// back-pressure, back-to-back stream and mid-MUL reset.
module tb_grey2rgb_colorize;
  import grey2rgb_pkg::*;

`ifdef GREY2RGB_ROUND_EN
  localparam logic [23:0] EXP_HALF  = 24'h804000;
  localparam logic [23:0] EXP_LUMA  = 24'h3C7617;
  localparam logic [23:0] EXP_SEPIA = 24'h644B32;
  localparam int          RND       = 128;
`else
  localparam logic [23:0] EXP_HALF  = 24'h7F4000;
  localparam logic [23:0] EXP_LUMA  = 24'h3C7516;
  localparam logic [23:0] EXP_SEPIA = 24'h634B32;
  localparam int          RND       = 0;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  grey2rgb_colorize_if g ();

  grey2rgb_colorize dut (.clk(clk), .rst(rst), .bus(g));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_chan(input logic [7:0] gr, input logic [7:0] c);
    int p;
    p = int'(gr) * int'(c) + RND;
    return 8'(p >> 8);
  endfunction

  task automatic drive(input logic [7:0] gr, input logic [7:0] cr, input logic [7:0] cg,
                       input logic [7:0] cb);
    g.grey_pixel = gr;
    g.coef_r     = cr;
    g.coef_g     = cg;
    g.coef_b     = cb;
  endtask

  // Waits at negedges after the acceptance edge; lat counts edges to out_valid.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!g.out_valid && lat < 32) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_pixel(input logic [7:0] gr, input logic [7:0] cr, input logic [7:0] cg,
                           input logic [7:0] cb, output int lat);
    @(negedge clk);
    drive(gr, cr, cg, cb);
    g.in_valid = 1'b1;
    @(negedge clk);
    g.in_valid = 1'b0;
    drive(~gr, 8'h5A, 8'hA5, 8'h3C);
    wait_result(lat);
  endtask

  logic [7:0]  s_gr [16];
  logic [7:0]  s_cr [16];
  logic [7:0]  s_cg [16];
  logic [7:0]  s_cb [16];
  logic [23:0] s_exp[16];

  initial begin
    int  lat;
    bit  stable;
    int  idx, oidx, cyc, last_t;
    bit  acc_now;

    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    g.in_valid = 1'b0;
    g.out_ready = 1'b0;
    drive(8'h00, 8'h00, 8'h00, 8'h00);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(g.out_valid), 32'd0);
    chk("rst_busy", 32'(g.busy), 32'd0);
    chk("rst_rgb", 32'(g.rgb_pixel), 32'h0);
    chk("rst_in_ready", 32'(g.in_ready), 32'd0);

    // Half-scale pixel accepted on the first edge after reset release
    rst = 1'b0;
    g.out_ready = 1'b1;
    drive(8'h80, 8'hFF, 8'h80, 8'h00);
    g.in_valid = 1'b1;
    #1;
    chk("first_in_ready", 32'(g.in_ready), 32'd1);
    @(negedge clk);
    g.in_valid = 1'b0;
    drive(8'hFF, 8'h11, 8'h22, 8'h33);
    chk("mul_busy", 32'(g.busy), 32'd1);
    chk("mul_in_ready", 32'(g.in_ready), 32'd0);
    wait_result(lat);
    chk("half_latency", 32'(lat), 32'd8);
    chk("half_rgb", 32'(g.rgb_pixel), 32'(EXP_HALF));
    @(negedge clk);
    chk("half_consumed", 32'(g.out_valid), 32'd0);
    chk("half_retained", 32'(g.rgb_pixel), 32'(EXP_HALF));
    chk("idle_busy", 32'(g.busy), 32'd0);

    // Boundaries and preset gains
    run_pixel(8'hFF, 8'hFF, 8'hFF, 8'hFF, lat);
    chk("full_latency", 32'(lat), 32'd8);
    chk("full_rgb", 32'(g.rgb_pixel), 32'hFEFEFE);
    run_pixel(8'h00, 8'hAB, 8'hCD, 8'hEF, lat);
    chk("zero_rgb", 32'(g.rgb_pixel), 32'h0);
    run_pixel(8'hC8, LUMA_R, LUMA_G, LUMA_B, lat);
    chk("luma_rgb", 32'(g.rgb_pixel), 32'(EXP_LUMA));

    // Back-pressure in HOLD, then combined consume-and-accept
    @(negedge clk);
    g.out_ready = 1'b0;
    run_pixel(8'h64, SEPIA_R, SEPIA_G, SEPIA_B, lat);
    chk("sepia_latency", 32'(lat), 32'd8);
    chk("sepia_rgb", 32'(g.rgb_pixel), 32'(EXP_SEPIA));
    drive(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    g.in_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (g.rgb_pixel !== EXP_SEPIA || g.out_valid !== 1'b1 || g.in_ready !== 1'b0)
        stable = 1'b0;
    end
    chk("hold_stable", 32'(stable), 32'd1);
    g.out_ready = 1'b1;
    drive(8'h80, 8'hFF, 8'h80, 8'h00);
    #1;
    chk("hold_in_ready", 32'(g.in_ready), 32'd1);
    @(negedge clk);
    g.in_valid = 1'b0;
    g.out_ready = 1'b0;
    drive(8'h01, 8'h02, 8'h03, 8'h04);
    chk("handoff_out_valid", 32'(g.out_valid), 32'd0);
    chk("handoff_busy", 32'(g.busy), 32'd1);
    wait_result(lat);
    chk("handoff_latency", 32'(lat), 32'd8);
    chk("handoff_rgb", 32'(g.rgb_pixel), 32'(EXP_HALF));
    g.out_ready = 1'b1;
    @(negedge clk);
    chk("handoff_consumed", 32'(g.out_valid), 32'd0);

    // Back-to-back stream
    for (int i = 0; i < 16; i++) begin
      s_gr[i]  = 8'(i * 37 + 11);
      s_cr[i]  = 8'(255 - i * 9);
      s_cg[i]  = 8'(i * 16);
      s_cb[i]  = 8'(i * 29 + 3);
      s_exp[i] = {ref_chan(s_gr[i], s_cr[i]), ref_chan(s_gr[i], s_cg[i]),
                  ref_chan(s_gr[i], s_cb[i])};
    end
    idx = 0;
    oidx = 0;
    cyc = 0;
    last_t = 0;
    drive(s_gr[0], s_cr[0], s_cg[0], s_cb[0]);
    g.in_valid = 1'b1;
    while (oidx < 16 && cyc < 400) begin
      if (g.out_valid) begin
        chk("stream_rgb", 32'(g.rgb_pixel), 32'(s_exp[oidx]));
        if (oidx > 0) chk("stream_spacing", 32'(cyc - last_t), 32'd9);
        last_t = cyc;
        oidx++;
      end
      acc_now = g.in_valid && g.in_ready;
      @(negedge clk);
      cyc++;
      if (acc_now) begin
        idx++;
        if (idx < 16) drive(s_gr[idx], s_cr[idx], s_cg[idx], s_cb[idx]);
        else g.in_valid = 1'b0;
      end
    end
    chk("stream_count", 32'(oidx), 32'd16);
    g.in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while the MAC is on bit k=4
    drive(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    g.in_valid = 1'b1;
    @(negedge clk);
    g.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(g.out_valid), 32'd0);
    chk("abort_busy", 32'(g.busy), 32'd0);
    chk("abort_in_ready", 32'(g.in_ready), 32'd0);
    chk("abort_rgb", 32'(g.rgb_pixel), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_pixel(8'h64, SEPIA_R, SEPIA_G, SEPIA_B, lat);
    chk("post_abort_latency", 32'(lat), 32'd8);
    chk("post_abort_rgb", 32'(g.rgb_pixel), 32'(EXP_SEPIA));
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
